// File: rtl/clkdiv_seq_pkg.sv
// clkdiv_seq_pkg: shared types, div_cfg field layout and host address map for the dwell sequencer
package clkdiv_seq_pkg;
  typedef enum logic [2:0] {IDLE, APPLY, RUN, DRAIN, GAP} state_t;
  localparam int CFG_W = 35;
  localparam int SEL_LSB = 0;
  localparam int FACTOR_LSB [4] = '{2, 10, 18, 26};
  localparam int EN_BIT = 34;
  // cfg_addr[1:0] picks the channel; cfg_addr[2] picks dwell (1) or factor (0)
  localparam int ADDR_DWELL_BIT = 2;
endpackage

// File: rtl/clkdiv_next_ch.sv
// clkdiv_next_ch: round-robin finder of the first eligible channel after cur, cur itself searched last
// ports: eligible (per-channel mask), cur (current channel), next_ch (found channel), any_eligible
module clkdiv_next_ch (
  input  logic [3:0] eligible,
  input  logic [1:0] cur,
  output logic [1:0] next_ch,
  output logic       any_eligible
);
  // scanning from the farthest offset down lets the nearest eligible channel win
  always_comb begin
    next_ch = cur;
    for (int i = 4; i >= 1; i--)
      if (eligible[2'(cur + 2'(i))]) next_ch = 2'(cur + 2'(i));
  end
  assign any_eligible = |eligible;
endmodule

// File: rtl/clkdiv_dwell_sequencer.sv
// clkdiv_dwell_sequencer: time-slices a 4-channel clock divider across channels with glitch-free switching
// ports: clk/rst (sync, active-high); cfg_valid/cfg_ready/cfg_addr/cfg_data host byte writes;
//        start/stop sequencing pulses; div_out divider feedback; div_cfg 35-bit divider config;
//        active_ch selected channel; running sequencing flag; switch_pulse high in the APPLY cycle
module clkdiv_dwell_sequencer
  import clkdiv_seq_pkg::*;
#(
  parameter int DWELL_SHIFT   = 4,
  parameter int DRAIN_TIMEOUT = 1023,
  parameter int GAP_CYCLES    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_addr,
  input  logic [7:0]       cfg_data,
  input  logic             start,
  input  logic             stop,
  input  logic             div_out,
  output logic [CFG_W-1:0] div_cfg,
  output logic [1:0]       active_ch,
  output logic             running,
  output logic             switch_pulse
);
  localparam int CW = 8 + DWELL_SHIFT;
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  state_t state, state_n;
  logic [7:0] dwell [4];
  logic [7:0] shadow [4];
  logic [3:0] pend, elig;
  logic [CW-1:0] dwell_cnt;
  logic [DW-1:0] drain_cnt;
  logic [GW-1:0] gap_cnt;
  logic [1:0] target, nxt, search_from;
  logic stop_pend, any, wr;
  assign elig = {|dwell[3], |dwell[2], |dwell[1], |dwell[0]};
  // from IDLE, searching after D yields the lowest-index eligible channel
  assign search_from = state == IDLE ? 2'd3 : active_ch;
  assign cfg_ready = state != APPLY;
  assign switch_pulse = state == APPLY;
  assign wr = cfg_valid && cfg_ready;
  clkdiv_next_ch u_next (
    .eligible(elig),
    .cur(search_from),
    .next_ch(nxt),
    .any_eligible(any)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start && !stop && any) state_n = APPLY;
      APPLY:   state_n = RUN;
      RUN:     if (stop || stop_pend || dwell_cnt == '0) state_n = DRAIN;
      DRAIN:   if (!div_out || drain_cnt == DW'(DRAIN_TIMEOUT)) state_n = GAP;
      GAP:     if (gap_cnt == GW'(GAP_CYCLES - 1)) state_n = (stop || stop_pend || !any) ? IDLE : APPLY;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      div_cfg <= '0;
      active_ch <= '0;
      running <= 1'b0;
      target <= '0;
      dwell_cnt <= '0;
      drain_cnt <= '0;
      gap_cnt <= '0;
      stop_pend <= 1'b0;
      pend <= '0;
      for (int i = 0; i < 4; i++) begin
        dwell[i] <= '0;
        shadow[i] <= '0;
      end
    end else begin
      state <= state_n;
      if (stop && state inside {RUN, DRAIN, GAP}) stop_pend <= 1'b1;
      // the live factor of the output channel is only touched at APPLY, so its writes are shadowed
      for (int i = 0; i < 4; i++)
        if (wr && cfg_addr[1:0] == 2'(i)) begin
          if (cfg_addr[ADDR_DWELL_BIT]) dwell[i] <= cfg_data;
          else if (running && active_ch == 2'(i)) begin
            shadow[i] <= cfg_data;
            pend[i] <= 1'b1;
          end else div_cfg[FACTOR_LSB[i] +: 8] <= cfg_data;
        end
      case (state)
        IDLE: target <= nxt;
        APPLY: begin
          for (int i = 0; i < 4; i++)
            if (pend[i]) div_cfg[FACTOR_LSB[i] +: 8] <= shadow[i];
          pend <= '0;
          div_cfg[SEL_LSB +: 2] <= target;
          div_cfg[EN_BIT] <= 1'b1;
          active_ch <= target;
          // ((dwell+1) << DWELL_SHIFT) - 1 is dwell with DWELL_SHIFT ones appended
          dwell_cnt <= {dwell[target], {DWELL_SHIFT{1'b1}}};
          running <= 1'b1;
        end
        RUN:
          if (state_n == DRAIN) begin
            target <= nxt;
            drain_cnt <= DW'(1);
          end else dwell_cnt <= dwell_cnt - CW'(1);
        DRAIN:
          if (state_n == GAP) begin
            div_cfg[EN_BIT] <= 1'b0;
            gap_cnt <= '0;
          end else if (drain_cnt != DW'(DRAIN_TIMEOUT)) drain_cnt <= drain_cnt + DW'(1);
        GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          if (state_n == IDLE) begin
            running <= 1'b0;
            stop_pend <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_clkdiv_dwell_sequencer.sv
// tb_clkdiv_dwell_sequencer: directed self-checking bench for the dwell sequencer
module tb_clkdiv_dwell_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [2:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic div_out = 1'b0;
  logic [34:0] div_cfg;
  logic [1:0] active_ch;
  logic running;
  logic switch_pulse;
  int tests = 0;
  int fails = 0;
  int n;

  clkdiv_dwell_sequencer dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .stop(stop),
    .div_out(div_out), .div_cfg(div_cfg), .active_ch(active_ch),
    .running(running), .switch_pulse(switch_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    int k = 0;
    cfg_valid = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    while (!cfg_ready && k < 8) begin
      tick();
      k++;
    end
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic with_stop);
    start = 1'b1;
    stop = with_stop;
    tick();
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_pulse(output int cnt);
    cnt = 0;
    while (!switch_pulse && cnt < 5000) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_cfg", div_cfg, 0);
    chk("rst_running", running, 0);
    chk("rst_pulse", switch_pulse, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_active", active_ch, 0);

    // 1: dwell A=1, D=2, immediate drains; A,D,A,D with 32/48-cycle RUNs
    wr(3'd4, 8'd1);
    wr(3'd7, 8'd2);
    pulse_start(1'b0);
    chk("t1_apply_pulse", switch_pulse, 1);
    chk("t1_apply_running", running, 0);
    chk("t1_apply_en", div_cfg[34], 0);
    tick();
    chk("t1_running", running, 1);
    chk("t1_en", div_cfg[34], 1);
    chk("t1_active_a", active_ch, 0);
    wait_pulse(n);
    chk("t1_gap_a", n, 35);
    tick();
    chk("t1_active_d", active_ch, 3);
    chk("t1_sel_d", div_cfg[1:0], 3);
    wait_pulse(n);
    chk("t1_gap_d", n, 51);
    tick();
    chk("t1_active_a2", active_ch, 0);
    wait_pulse(n);
    chk("t1_gap_a2", n, 35);
    tick();
    chk("t1_active_d2", active_ch, 3);

    // 2: div_out stuck high -> drain timeout, then 2 gap cycles with enable low
    div_out = 1'b1;
    n = 0;
    while (div_cfg[34] && n < 3000) begin
      tick();
      n++;
    end
    chk("t2_en_fall", n, 1071);
    tick();
    chk("t2_gap2_en", div_cfg[34], 0);
    chk("t2_gap2_pulse", switch_pulse, 0);
    tick();
    chk("t2_apply_pulse", switch_pulse, 1);
    chk("t2_apply_sel", div_cfg[1:0], 3);
    tick();
    chk("t2_new_sel", div_cfg[1:0], 0);
    chk("t2_new_en", div_cfg[34], 1);
    div_out = 1'b0;

    // 3: shadowed factor write to active B, direct write to C
    do_reset();
    wr(3'd5, 8'd3);
    wr(3'd1, 8'h22);
    chk("t3_idle_fb", div_cfg[17:10], 8'h22);
    pulse_start(1'b0);
    tick();
    chk("t3_active_b", active_ch, 1);
    wr(3'd1, 8'h33);
    chk("t3_fb_held", div_cfg[17:10], 8'h22);
    wr(3'd1, 8'h10);
    wr(3'd2, 8'h05);
    chk("t3_fc_direct", div_cfg[25:18], 8'h05);
    chk("t3_fb_held2", div_cfg[17:10], 8'h22);
    wait_pulse(n);
    chk("t3_reapply", switch_pulse, 1);
    chk("t3_fb_at_apply", div_cfg[17:10], 8'h22);
    tick();
    chk("t3_fb_commit", div_cfg[17:10], 8'h10);
    chk("t3_active_b2", active_ch, 1);

    // 4: stop mid-RUN drains to IDLE; start+stop in IDLE is ignored
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n = 0;
    while (running && n < 100) begin
      tick();
      n++;
    end
    chk("t4_stop_len", n, 3);
    chk("t4_stop_en", div_cfg[34], 0);
    pulse_start(1'b1);
    chk("t4_both_pulse", switch_pulse, 0);
    tick();
    chk("t4_both_running", running, 0);

    // 5: no eligible channel ignores start; write during APPLY is deferred
    do_reset();
    pulse_start(1'b0);
    chk("t5_noelig_pulse", switch_pulse, 0);
    tick();
    chk("t5_noelig_running", running, 0);
    wr(3'd4, 8'd1);
    pulse_start(1'b0);
    chk("t5_apply_ready", cfg_ready, 0);
    cfg_valid = 1'b1;
    cfg_addr = 3'd2;
    cfg_data = 8'h07;
    tick();
    chk("t5_deferred", div_cfg[25:18], 8'h00);
    chk("t5_ready_back", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    chk("t5_written", div_cfg[25:18], 8'h07);

    // 6: reset in RUN clears everything
    wr(3'd1, 8'h44);
    chk("t6_fb", div_cfg[17:10], 8'h44);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_cfg", div_cfg, 0);
    chk("t6_running", running, 0);
    chk("t6_active", active_ch, 0);
    chk("t6_ready", cfg_ready, 1);
    pulse_start(1'b0);
    chk("t6_dwell_cleared", switch_pulse, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
